// File: rtl/hamming_enc_stream_if.sv
// Handshake bundle for the streaming Hamming encoder: source side (word + injection
// control) and sink side (codeword), both seen from the encoder as the slave.
interface hamming_enc_stream_if #(
  parameter int DATA_W = 4,
  parameter int CODE_W = 7,
  parameter int POS_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              inj_en;
  logic [POS_W-1:0]  inj_pos;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;

  modport master (
    output in_valid, in_data, inj_en, inj_pos, out_ready,
    input  in_ready, out_valid, out_code
  );

  modport slave (
    input  in_valid, in_data, inj_en, inj_pos, out_ready,
    output in_ready, out_valid, out_code
  );
endinterface

// File: rtl/hamming_enc_stream.sv
// Pipelined Hamming (optionally SECDED) encoder with bit-flip injection, a credit-based
// input handshake and a show-ahead output FIFO.
module hamming_enc_stream #(
  parameter int DATA_W = 4,
  parameter int SECDED = 0,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hamming_enc_stream_if.slave    bus,
  output logic [CNT_W-1:0]       word_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  function automatic int calc_par_w(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p = p + 1;
    return p;
  endfunction

  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int HAM_W  = DATA_W + PAR_W;
  localparam int CODE_W = HAM_W + SECDED;
  localparam int POS_W  = $clog2(CODE_W);
  localparam int AW     = $clog2(DEPTH);
  localparam int LVL_W  = AW + 1;

  // Data fills non-power-of-two positions; parity j covers positions with bit j set.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [HAM_W-1:0]  h;
    logic [CODE_W-1:0] c;
    logic              p;
    int                di;
    h  = '0;
    di = 0;
    for (int i = 1; i <= HAM_W; i++) begin
      if (((i & (i - 1)) != 0) && (di < DATA_W)) begin
        h[i-1] = d[di];
        di = di + 1;
      end
    end
    for (int j = 0; j < PAR_W; j++) begin
      p = 1'b0;
      for (int i = 1; i <= HAM_W; i++) begin
        if (i[j]) p = p ^ h[i-1];
      end
      h[(1 << j) - 1] = p;
    end
    c = '0;
    c[HAM_W-1:0] = h;
    if (SECDED != 0) c[CODE_W-1] = ^h;
    return c;
  endfunction

  function automatic logic [CODE_W-1:0] inject(input logic [CODE_W-1:0] c,
                                               input logic en,
                                               input logic [POS_W-1:0] pos);
    logic [CODE_W-1:0] r;
    r = c;
    if (en && (32'(pos) < CODE_W)) r = c ^ (CODE_W'(1) << pos);
    return r;
  endfunction

  logic                  accept_p0;
  logic                  vld_p1;
  logic [CODE_W-1:0]     code_p1;
  logic [CODE_W-1:0]     mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  pop;
  logic [LVL_W:0]        credit;

  // Credits count the word sitting in stage 1, so the FIFO write never has to stall.
  assign credit       = {1'b0, fifo_level} + (LVL_W + 1)'(vld_p1);
  assign bus.in_ready = !rst && (credit < (LVL_W + 1)'(DEPTH));
  assign accept_p0    = bus.in_valid && bus.in_ready;

  // Stage 0 -> 1: encode and inject
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept_p0;
  end

  always_ff @(posedge clk) begin
    code_p1 <= inject(encode(bus.in_data), bus.inj_en, bus.inj_pos);
  end

  always_ff @(posedge clk) begin
    if (rst)            word_count <= '0;
    else if (accept_p0) word_count <= word_count + CNT_W'(1);
  end

  // Stage 1 -> FIFO
  always_ff @(posedge clk) begin
    if (vld_p1) mem[wr_ptr] <= code_p1;
  end

  assign bus.out_valid = (fifo_level != '0);
  assign bus.out_code  = bus.out_valid ? mem[rd_ptr] : '0;
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (vld_p1) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({vld_p1, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Bench for hamming_enc_stream: a plain and a SECDED instance driven in lockstep,
// each checked by a queue scoreboard against a syndrome-based reference model.
module tb_hamming_enc_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       inj_en = 1'b0;
  logic [2:0] inj_pos = '0;
  logic       out_ready = 1'b0;

  logic [3:0]  wc_a;
  logic [15:0] wc_b;
  logic [2:0]  lvl_a;
  logic [2:0]  lvl_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_acc = 0;

  logic [7:0] exp_q [2][$];
  bit         acc_prev [2];
  bit         stall_prev [2];
  int         cnt_m [2];

  hamming_enc_stream_if #(.DATA_W(4), .CODE_W(7), .POS_W(3)) ifa ();
  hamming_enc_stream_if #(.DATA_W(4), .CODE_W(8), .POS_W(3)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.inj_en    = inj_en;
  assign ifa.inj_pos   = inj_pos;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.inj_en    = inj_en;
  assign ifb.inj_pos   = inj_pos;
  assign ifb.out_ready = out_ready;

  hamming_enc_stream #(.DATA_W(4), .SECDED(0), .DEPTH(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .word_count(wc_a), .fifo_level(lvl_a));

  hamming_enc_stream #(.DATA_W(4), .SECDED(1), .DEPTH(4), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .word_count(wc_b), .fifo_level(lvl_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Parity bits are the binary digits of the XOR of the positions of all set data bits.
  function automatic logic [7:0] model(input logic [3:0] d, input bit secded,
                                       input logic ie, input logic [2:0] ip);
    logic [7:0] c;
    int syn;
    int k;
    int cw;
    c = '0;
    syn = 0;
    k = 0;
    cw = secded ? 8 : 7;
    for (int pos = 1; k < 4; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        if (d[k]) syn = syn ^ pos;
        k++;
      end
    end
    c[0] = syn[0];
    c[1] = syn[1];
    c[3] = syn[2];
    if (secded) c[7] = ^c[6:0];
    if (ie && (int'(ip) < cw)) c[ip] = ~c[ip];
    return c;
  endfunction

  task automatic mon(input int u, input logic ir, input logic ov, input logic [7:0] oc,
                     input logic [2:0] lvl, input logic [15:0] wc, input int mask);
    bit acc;
    if (rst) begin
      exp_q[u].delete();
      acc_prev[u] = 0;
      stall_prev[u] = 0;
      cnt_m[u] = 0;
      return;
    end
    chk($sformatf("in_ready[%0d]", u), 64'(ir), 64'(exp_q[u].size() < 4));
    chk($sformatf("fifo_level[%0d]", u), 64'(lvl), 64'(exp_q[u].size() - int'(acc_prev[u])));
    chk($sformatf("word_count[%0d]", u), 64'(wc), 64'(cnt_m[u] & mask));
    if (stall_prev[u]) chk($sformatf("stall out_valid[%0d]", u), 64'(ov), 64'(1));
    if (ov) begin
      if (exp_q[u].size() == 0) begin
        chk($sformatf("unexpected word[%0d]", u), 64'(oc), 64'hdead);
      end else begin
        chk($sformatf("out_code[%0d]", u), 64'(oc), 64'(exp_q[u][0]));
        if (out_ready) void'(exp_q[u].pop_front());
      end
    end
    stall_prev[u] = ov && !out_ready;
    acc = in_valid && ir;
    if (acc) begin
      exp_q[u].push_back(model(in_data, u == 1, inj_en, inj_pos));
      cnt_m[u]++;
      if (u == 0) n_acc++;
    end
    acc_prev[u] = acc;
  endtask

  always @(negedge clk) begin
    mon(0, ifa.in_ready, ifa.out_valid, 8'(ifa.out_code), lvl_a, 16'(wc_a), 32'hF);
    mon(1, ifb.in_ready, ifb.out_valid, ifb.out_code, lvl_b, wc_b, 32'hFFFF);
  end

  task automatic send(input logic [3:0] d, input logic ie, input logic [2:0] ip);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    inj_en   = ie;
    inj_pos  = ip;
    @(negedge clk);
    while (!ifa.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send timeout", 64'(t), 64'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inj_en   = 1'b0;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    @(negedge clk);
    while ((ifa.out_valid || ifb.out_valid || lvl_a != 0 || lvl_b != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("drain timeout", 64'(t), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst out_valid_a", 64'(ifa.out_valid), 64'(0));
    chk("rst out_valid_b", 64'(ifb.out_valid), 64'(0));
    chk("rst fifo_level_a", 64'(lvl_a), 64'(0));
    chk("rst fifo_level_b", 64'(lvl_b), 64'(0));
    chk("rst word_count_a", 64'(wc_a), 64'(0));
    chk("rst word_count_b", 64'(wc_b), 64'(0));
    chk("rst out_code_a", 64'(ifa.out_code), 64'(0));
    chk("rst out_code_b", 64'(ifb.out_code), 64'(0));
    chk("rst in_ready_a", 64'(ifa.in_ready), 64'(0));
    chk("rst in_ready_b", 64'(ifb.in_ready), 64'(0));
  endtask

  task automatic kat(input logic [3:0] d, input logic ie, input logic [2:0] ip,
                     input logic [6:0] ea, input logic [7:0] eb);
    out_ready = 1'b0;
    send(d, ie, ip);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("kat valid d=%0h", d), 64'(ifa.out_valid), 64'(1));
    chk($sformatf("kat code_a d=%0h ie=%0d ip=%0d", d, ie, ip), 64'(ifa.out_code), 64'(ea));
    chk($sformatf("kat code_b d=%0h ie=%0d ip=%0d", d, ie, ip), 64'(ifb.out_code), 64'(eb));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_empty();
  endtask

  initial begin
    int c0;
    int b0;
    int sent;
    int guard;
    bit acc;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", 64'(ifa.in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Sweep all data values back to back with the sink always ready.
    out_ready = 1'b1;
    c0 = cyc;
    b0 = int'(wc_b);
    for (int d = 0; d < 16; d++) send(4'(d), 1'b0, 3'd0);
    chk("sweep cycles", 64'(cyc - c0), 64'(16));
    wait_empty();
    chk("sweep word_count_b", 64'(wc_b), 64'(b0 + 16));

    // Known answers, including injection.
    kat(4'b0000, 1'b0, 3'd0, 7'b0000000, 8'b00000000);
    kat(4'b1011, 1'b0, 3'd0, 7'b1010101, 8'b01010101);
    kat(4'b1111, 1'b0, 3'd0, 7'b1111111, 8'b11111111);
    kat(4'b0001, 1'b0, 3'd0, 7'b0000111, 8'b10000111);
    kat(4'b0000, 1'b1, 3'd2, 7'b0000100, 8'b00000100);
    kat(4'b0000, 1'b1, 3'd7, 7'b0000000, 8'b10000000);

    // Back-pressure: sink stalled, source always valid.
    out_ready = 1'b0;
    n_acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 4'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full accepted", 64'(n_acc), 64'(4));
    chk("full fifo_level", 64'(lvl_a), 64'(4));
    chk("full in_ready", 64'(ifa.in_ready), 64'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_empty();
    @(negedge clk);
    chk("in_ready after drain", 64'(ifa.in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Random traffic with random sink stalls and injection.
    sent = 0;
    guard = 0;
    in_valid = 1'b0;
    while (sent < 1000 && guard < 20000) begin
      @(negedge clk);
      acc = in_valid && ifa.in_ready;
      if (acc) sent++;
      @(posedge clk);
      #1;
      guard++;
      out_ready = ($urandom_range(0, 1) == 1);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 4'($urandom);
        inj_en   = ($urandom_range(0, 3) == 0);
        inj_pos  = 3'($urandom);
      end
    end
    in_valid = 1'b0;
    inj_en = 1'b0;
    chk("random words sent", 64'(sent), 64'(1000));
    out_ready = 1'b1;
    wait_empty();
    chk("scoreboard empty a", 64'(exp_q[0].size()), 64'(0));
    chk("scoreboard empty b", 64'(exp_q[1].size()), 64'(0));

    // Reset with words queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'(i + 5), 1'b0, 3'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after mid reset", 64'(ifa.in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Counter wrap on the 4-bit instance.
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(4'($urandom), 1'b0, 3'd0);
    @(negedge clk);
    chk("wrap word_count_a", 64'(wc_a), 64'(1));
    chk("wrap word_count_b", 64'(wc_b), 64'(17));
    @(posedge clk);
    #1;
    wait_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
